alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal values 8..64, powers of two).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit, indicating that the request fields are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit, indicating that the unit can accept a request.
REQ-006 The block SHALL have port alu_op, input, 2 bits: 00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-007 The block SHALL have port funct7, input, 7 bits, the full instruction funct7 field.
REQ-008 The block SHALL have port funct3, input, 3 bits, the instruction funct3 field.
REQ-009 The block SHALL have ports op_a and op_b, inputs, WIDTH bits each, carrying the operands.
REQ-010 The block SHALL have port out_valid, output, 1 bit, indicating that the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit, the consumer acceptance signal.
REQ-012 The block SHALL have port result, output, WIDTH bits, the registered result.
REQ-013 The block SHALL have port zero, output, 1 bit, asserted when result equals 0.
REQ-014 The block SHALL have port operation, output, 4 bits, the registered decoded operation code.
REQ-015 The block SHALL have port err, output, 1 bit, asserted when the accepted request was an illegal decode.

Function
REQ-016 Operation codes SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, SRA 1001, MUL 1010.
REQ-017 Decode SHALL be as follows:
- alu_op 00 gives ADD and alu_op 01 gives SUB, ignoring funct fields.
- alu_op 10 with funct7 0000000 decodes funct3 as 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- alu_op 10 with funct7 0100000 decodes funct3 000 as SUB and 101 as SRA.
- alu_op 11 decodes funct3 the same as R-type, never SUB; funct3 101 gives SRA if funct7[5]=1, else SRL.
REQ-018 alu_op 10 with funct7 0000001 and funct3 000 SHALL decode as MUL; every other undefined combination SHALL be illegal.
REQ-019 Shift amount SHALL be op_b[log2(WIDTH)-1:0]; SLT SHALL compare signed and SLTU unsigned, producing a 0/1 result zero-extended to WIDTH.
REQ-020 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH; MUL SHALL return the low WIDTH bits of the product.
REQ-021 The FSM SHALL have three states:
- IDLE: in_ready=1.
- BUSY: MUL iteration in progress, in_ready=0.
- DONE: out_valid=1, in_ready=0.
REQ-022 A transfer SHALL occur when in_valid=1 and in_ready=1; the operands, the decode and any illegal status SHALL be captured on that edge.
REQ-023 A non-MUL op accepted at edge N SHALL enter DONE with its result at edge N+1 (1-cycle latency).
REQ-024 MUL SHALL enter BUSY and run an iterative shift-add, one operand bit per cycle, entering DONE after exactly WIDTH cycles in BUSY (latency WIDTH+1).
REQ-025 An illegal request SHALL go directly to DONE after 1 cycle with result=0, operation=0010 and err=1.
REQ-026 In DONE, result, operation, zero and err SHALL be held stable until out_valid and out_ready are both high, after which the FSM SHALL return to IDLE on the same edge.
REQ-027 in_ready SHALL be deasserted in DONE even if out_ready=1, so at most one request is in flight.

Reset
REQ-028 Reset SHALL asynchronously force IDLE with in_ready=1, out_valid=0, result=0, zero=1, operation=0000 and err=0.
REQ-029 Reset asserted while in BUSY or DONE SHALL abort the operation and discard its result; no out_valid SHALL be produced for it.

Configuration
REQ-030 The macro ALU_EXEC_MUL_EN SHALL control multiply support:
- Defined: MUL is supported per REQ-018 and REQ-024.
- Undefined: the BUSY state and the multiplier logic SHALL be absent, and the funct7 0000001 MUL encoding SHALL decode as illegal per REQ-025.

Verification
REQ-031 The bench SHALL cover, with WIDTH=32:
- alu_op 10, funct7 0100000, funct3 000, op_a 5, op_b 7 -> next cycle out_valid=1, result FFFFFFFE, operation 0110, zero=0.
- alu_op 11, funct7 0100000, funct3 101, op_a 80000000, op_b 4 -> result F8000000, operation 1001.
- With MUL_EN: MUL of FFFFFFFF by 3 -> out_valid exactly 33 cycles after acceptance, result FFFFFFFD; in_ready=0 throughout.
- alu_op 10, funct7 0000001, funct3 100 -> err=1, result 0; with out_ready held 0 for 5 cycles, the outputs are stable and in_ready=0.
- Reset asserted 10 cycles into a MUL -> immediately out_valid=0 and in_ready=1, and no result ever appears.
- alu_op 00, op_a 1, op_b FFFFFFFF -> result 0, zero=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - single-issue ALU with registered result and valid/ready handshakes
// Define ALU_EXEC_MUL_EN to add the iterative shift-add MUL (BUSY state); otherwise that encoding decodes as illegal.
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_op,
   input  logic [6:0]       funct7,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [3:0]       operation,
   output logic             err
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;
`ifdef ALU_EXEC_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DONE = 2'd1
`ifdef ALU_EXEC_MUL_EN
      , S_BUSY = 2'd2
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       op_q, op_d;
   logic             err_q, err_d;
`ifdef ALU_EXEC_MUL_EN
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
`endif

   logic [3:0]       base_op;
   logic [3:0]       dec_op;
   logic             dec_ill;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;

   always_comb begin
      base_op = OP_ADD;
      case (funct3)
         3'b000:  base_op = OP_ADD;
         3'b001:  base_op = OP_SLL;
         3'b010:  base_op = OP_SLT;
         3'b011:  base_op = OP_SLTU;
         3'b100:  base_op = OP_XOR;
         3'b101:  base_op = OP_SRL;
         3'b110:  base_op = OP_OR;
         default: base_op = OP_AND;
      endcase
   end

   // I-type never yields SUB; its funct7 only matters to pick SRA over SRL
   always_comb begin
      dec_op  = OP_ADD;
      dec_ill = 1'b0;
      case (alu_op)
         2'b00: dec_op = OP_ADD;
         2'b01: dec_op = OP_SUB;
         2'b10: begin
            if (funct7 == 7'b0000000)
               dec_op = base_op;
            else if (funct7 == 7'b0100000 && funct3 == 3'b000)
               dec_op = OP_SUB;
            else if (funct7 == 7'b0100000 && funct3 == 3'b101)
               dec_op = OP_SRA;
`ifdef ALU_EXEC_MUL_EN
            else if (funct7 == 7'b0000001 && funct3 == 3'b000)
               dec_op = OP_MUL;
`endif
            else
               dec_ill = 1'b1;
         end
         default: dec_op = (funct3 == 3'b101 && funct7[5]) ? OP_SRA : base_op;
      endcase
   end

   assign shamt = op_b[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (dec_op)
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_ADD:  alu_res = op_a + op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLL:  alu_res = op_a << shamt;
         OP_SRL:  alu_res = op_a >> shamt;
         OP_SUB:  alu_res = op_a - op_b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
         OP_SRA:  alu_res = $signed(op_a) >>> shamt;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      op_d     = op_q;
      err_d    = err_q;
`ifdef ALU_EXEC_MUL_EN
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d     = dec_ill ? OP_ADD : dec_op;
               err_d    = dec_ill;
               result_d = dec_ill ? '0 : alu_res;
               state_d  = S_DONE;
`ifdef ALU_EXEC_MUL_EN
               if (!dec_ill && dec_op == OP_MUL) begin
                  result_d = '0;
                  mcand_d  = op_a;
                  mplier_d = op_b;
                  cnt_d    = '0;
                  state_d  = S_BUSY;
               end
`endif
            end
         end
`ifdef ALU_EXEC_MUL_EN
         // result_q doubles as the accumulator; out_valid is low so it may move
         S_BUSY: begin
            if (mplier_q[0])
               result_d = result_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == SHW'(WIDTH - 1))
               state_d = S_DONE;
         end
`endif
         S_DONE: begin
            if (out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         op_q     <= OP_AND;
         err_q    <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         op_q     <= op_d;
         err_q    <= err_d;
`ifdef ALU_EXEC_MUL_EN
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign zero      = (result_q == '0);
   assign operation = op_q;
   assign err       = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - vector table, corner sequences and random checks for alu_exec_unit
// MUL expectations follow ALU_EXEC_MUL_EN.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  alu_op = '0;
   logic [6:0]  funct7 = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero;
   logic [3:0]  operation;
   logic        err;

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
      .operation(operation), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  aop;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  op;
      logic        e;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [3:0] op, output logic [31:0] r, output logic e);
      logic [3:0]  base;
      logic [63:0] wide;
      int sh;
      sh = int'(b % 32);
      e = 1'b0;
      r = '0;
      case (f3)
         3'd0: base = 4'd2;  3'd1: base = 4'd4;  3'd2: base = 4'd7;  3'd3: base = 4'd8;
         3'd4: base = 4'd3;  3'd5: base = 4'd5;  3'd6: base = 4'd1;  default: base = 4'd0;
      endcase
      if (aop == 2'b00) op = 4'd2;
      else if (aop == 2'b01) op = 4'd6;
      else if (aop == 2'b11) op = (f3 == 3'd5 && f7[5]) ? 4'd9 : base;
      else if (f7 == 7'h00) op = base;
      else if (f7 == 7'h20 && f3 == 3'd0) op = 4'd6;
      else if (f7 == 7'h20 && f3 == 3'd5) op = 4'd9;
`ifdef ALU_EXEC_MUL_EN
      else if (f7 == 7'h01 && f3 == 3'd0) op = 4'd10;
`endif
      else begin
         op = 4'd2;
         e = 1'b1;
      end
      if (!e) begin
         case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a + b;
            4'd3: r = a ^ b;
            4'd4: r = a * (32'd1 << sh);
            4'd5: r = a / (32'd1 << sh);
            4'd6: r = a - b;
            4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: r = (a < b) ? 32'd1 : 32'd0;
            4'd9: begin
               wide = {{32{a[31]}}, a} >> sh;
               r = wide[31:0];
            end
            default: begin
               wide = {32'd0, a} * {32'd0, b};
               r = wide[31:0];
            end
         endcase
      end
   endtask

   task automatic issue(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
      alu_op = aop; funct7 = f7; funct3 = f3; op_a = a; op_b = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic run_req(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eres, input logic [3:0] eop, input logic eerr);
      int lat;
      int exp_lat;
      bit rdy_seen;
      exp_lat = (eop == 4'd10 && !eerr) ? 33 : 1;
      issue(aop, f7, f3, a, b);
      lat = 1;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 100) begin
         rdy_seen |= in_ready;
         @(posedge clk);
         #1 lat++;
      end
      rdy_seen |= in_ready;
      chk($sformatf("%s.lat", tag), lat, exp_lat);
      chk($sformatf("%s.in_ready_low", tag), rdy_seen, 0);
      chk($sformatf("%s.result", tag), result, eres);
      chk($sformatf("%s.operation", tag), operation, eop);
      chk($sformatf("%s.zero", tag), zero, (eres == 0));
      chk($sformatf("%s.err", tag), err, eerr);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk($sformatf("%s.release", tag), {out_valid, in_ready}, 2'b01);
   endtask

   initial begin
      logic [3:0]  mop;
      logic [31:0] mres;
      logic        merr;
      logic [1:0]  raop;
      logic [6:0]  rf7;
      logic [2:0]  rf3;
      logic [31:0] ra, rb;
      bit ok;

      vecs.push_back('{2'b10, 7'h20, 3'd0, 32'd5, 32'd7, 32'hFFFFFFFE, 4'd6, 1'b0});
      vecs.push_back('{2'b11, 7'h20, 3'd5, 32'h80000000, 32'd4, 32'hF8000000, 4'd9, 1'b0});
      vecs.push_back('{2'b00, 7'h55, 3'd3, 32'd1, 32'hFFFFFFFF, 32'd0, 4'd2, 1'b0});
      vecs.push_back('{2'b10, 7'h01, 3'd4, 32'd9, 32'd9, 32'd0, 4'd2, 1'b1});
      vecs.push_back('{2'b10, 7'h00, 3'd2, 32'hFFFFFFFF, 32'd1, 32'd1, 4'd7, 1'b0});
      vecs.push_back('{2'b10, 7'h00, 3'd3, 32'hFFFFFFFF, 32'd1, 32'd0, 4'd8, 1'b0});
      vecs.push_back('{2'b10, 7'h00, 3'd1, 32'd1, 32'h24, 32'h10, 4'd4, 1'b0});
      vecs.push_back('{2'b11, 7'h00, 3'd5, 32'h80000000, 32'd4, 32'h08000000, 4'd5, 1'b0});
      vecs.push_back('{2'b01, 7'h7F, 3'd7, 32'd3, 32'd3, 32'd0, 4'd6, 1'b0});
      vecs.push_back('{2'b10, 7'h20, 3'd1, 32'd3, 32'd3, 32'd0, 4'd2, 1'b1});
      vecs.push_back('{2'b10, 7'h00, 3'd7, 32'hF0F0, 32'hFF00, 32'hF000, 4'd0, 1'b0});
      vecs.push_back('{2'b10, 7'h00, 3'd6, 32'hF0F0, 32'hFF00, 32'hFFF0, 4'd1, 1'b0});
      vecs.push_back('{2'b11, 7'h20, 3'd0, 32'd5, 32'd7, 32'd12, 4'd2, 1'b0});
      vecs.push_back('{2'b10, 7'h00, 3'd4, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 4'd3, 1'b0});
`ifdef ALU_EXEC_MUL_EN
      vecs.push_back('{2'b10, 7'h01, 3'd0, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 4'd10, 1'b0});
`else
      vecs.push_back('{2'b10, 7'h01, 3'd0, 32'hFFFFFFFF, 32'd3, 32'd0, 4'd2, 1'b1});
`endif

      #12;
      chk("reset.state", {in_ready, out_valid, zero, err, operation}, {1'b1, 1'b0, 1'b1, 1'b0, 4'd0});
      chk("reset.result", result, 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i])
         run_req($sformatf("vec%0d", i), vecs[i].aop, vecs[i].f7, vecs[i].f3, vecs[i].a,
                 vecs[i].b, vecs[i].res, vecs[i].op, vecs[i].e);

      // illegal request held in DONE while the consumer stalls
      issue(2'b10, 7'h01, 3'd4, 32'd1, 32'd2);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ok &= (out_valid === 1'b1) && (result === 32'd0) && (err === 1'b1) &&
               (operation === 4'd2) && (in_ready === 1'b0);
         @(posedge clk);
         #1;
      end
      chk("illegal.hold", ok, 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("illegal.release", in_ready, 1);

`ifdef ALU_EXEC_MUL_EN
      issue(2'b10, 7'h01, 3'd0, 32'h1234, 32'h5678);
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      #1 chk("mulabort.now", {out_valid, in_ready}, 2'b01);
`else
      issue(2'b00, 7'h00, 3'd0, 32'h1234, 32'h5678);
      #1 reset = 1'b1;
      #1 chk("doneabort.now", {out_valid, in_ready}, 2'b01);
`endif
      chk("abort.regs", {zero, err, operation, result}, {1'b1, 1'b0, 4'd0, 32'd0});
      @(negedge clk);
      reset = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         ok &= (out_valid === 1'b0);
      end
      chk("abort.no_result", ok, 1);

      for (int n = 0; n < 150; n++) begin
         raop = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: rf7 = 7'h00;
            1: rf7 = 7'h20;
            2: rf7 = 7'h01;
            default: rf7 = 7'($urandom);
         endcase
         rf3 = 3'($urandom);
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         model(raop, rf7, rf3, ra, rb, mop, mres, merr);
         run_req($sformatf("rand%0d", n), raop, rf7, rf3, ra, rb, mres, mop, merr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
